// File: rtl/tilelink_ad_pkg.sv
// tilelink_ad_pkg
// Shared definitions for the TileLink-UL A/D initiator and its responder
// counterpart (tilelink_ad_dummy).
//   - A and D channel opcode encodings
//   - initiator FSM state enum
//   - expected_d_opcode(): the D opcode that answers a given A request
//   - beat_count(): number of D beats a request produces
package tilelink_ad_pkg;

  // Channel A opcodes
  localparam logic [2:0] A_PUT_FULL_DATA = 3'd0;
  localparam logic [2:0] A_GET           = 3'd4;

  // Channel D opcodes
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    ERR  = 3'd3,
    HUNG = 3'd4
  } state_t;

  // A Put is acknowledged without data; a Get returns data.
  function automatic logic [2:0] expected_d_opcode(input logic write);
    return write ? D_ACCESS_ACK : D_ACCESS_ACK_DATA;
  endfunction

  // A Get larger than one bus word is split into bus-word beats. A Put is
  // always one beat, and anything smaller than a bus word is still one beat.
  // The result saturates at 16 so it fits the 4-bit beat counter for any
  // legal size.
  function automatic logic [4:0] beat_count(input logic write,
                                            input logic [2:0] size,
                                            input int lb);
    int n;
    n = (32'd1 << size) >> lb;
    if (write || n < 1) begin
      return 5'd1;
    end
    if (n > 16) begin
      return 5'd16;
    end
    return 5'(n);
  endfunction

endpackage

// File: rtl/tilelink_ad_mask_gen.sv
// tilelink_ad_mask_gen
// Combinational byte-lane mask for a TileLink A request.
// Ports:
//   size      in  3      log2 of the transfer size in bytes
//   addr_lsbs in  LB     byte offset of the address within the bus word
//   mask      out BYTES  one bit per active byte lane
// Transfers of a full bus word or larger enable every lane; smaller ones
// enable 1<<size lanes starting at the address offset.
module tilelink_ad_mask_gen #(
  parameter int BYTES = 4,
  parameter int LB    = 2
) (
  input  logic [2:0]       size,
  input  logic [LB-1:0]    addr_lsbs,
  output logic [BYTES-1:0] mask
);

  // Per-lane window test: lane i is active when it falls inside
  // [offset, offset + (1<<size)).
  always_comb begin
    mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (int'(size) >= LB) begin
        mask[i] = 1'b1;
      end else if ((i >= int'(addr_lsbs)) &&
                   (i < int'(addr_lsbs) + int'(32'd1 << size))) begin
        mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tilelink_ad_initiator.sv
// tilelink_ad_initiator
// TileLink-UL A/D initiator. Each accepted command becomes one Get or
// PutFullData on channel A; the channel D beats come back one by one on the
// response port. One transaction is outstanding at a time.
// Ports:
//   clock, reset_n              clock, synchronous active-low reset
//   cmd_valid/ready             command handshake
//   cmd_write/address/size/data command fields (1=Put, 0=Get)
//   a_valid/ready, a_bits_*     channel A (initiator drives)
//   d_valid/ready, d_bits_*     channel D (responder drives)
//   rsp_valid/ready             response handshake
//   rsp_data/last/error         response fields
//   proto_err                   sticky: a D beat had a wrong opcode/source/size
//   hung                        sticky: watchdog fired, waiting for reset
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

module tilelink_ad_initiator
  import tilelink_ad_pkg::*;
#(
  parameter int XLEN      = `RISCV_FORMAL_XLEN,
  parameter int SRC_W     = 5,
  parameter int SOURCE_ID = 0,
  parameter int MAX_SIZE  = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_address,
  input  logic [2:0]            cmd_size,
  input  logic [XLEN-1:0]       cmd_data,

  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [2:0]            a_bits_opcode,
  output logic [2:0]            a_bits_param,
  output logic [2:0]            a_bits_size,
  output logic [SRC_W-1:0]      a_bits_source,
  output logic [31:0]           a_bits_address,
  output logic [XLEN/8-1:0]     a_bits_mask,
  output logic [XLEN-1:0]       a_bits_data,

  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [2:0]            d_bits_opcode,
  input  logic [2:0]            d_bits_size,
  input  logic [SRC_W-1:0]      d_bits_source,
  input  logic [XLEN-1:0]       d_bits_data,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_error,

  output logic                  proto_err,
  output logic                  hung
);

  localparam int BYTES = XLEN / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int WD_W  = $clog2(TIMEOUT) + 1;

  state_t state;
  state_t state_next;

  logic              cmd_write_q;
  logic [31:0]       cmd_address_q;
  logic [2:0]        cmd_size_q;
  logic [XLEN-1:0]   cmd_data_q;

  logic [3:0]        beat_cnt;
  logic [WD_W-1:0]   wd_cnt;

  // err_sent: the ERR response is already sitting in the response register.
  // hang_rsp_pending: watchdog fired while the register was still occupied.
  logic              err_sent;
  logic              hang_rsp_pending;

  logic              cmd_fire;
  logic              a_fire;
  logic              d_fire;
  logic              rsp_fire;
  logic              rsp_free;
  logic              cmd_illegal;
  logic [4:0]        beats;
  logic              final_beat;
  logic              d_mismatch;
  logic              timeout;
  logic              load_d;
  logic              load_err;
  logic              load_hang;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign a_fire   = a_valid && a_ready;
  assign d_fire   = d_valid && d_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // The single response slot can take a new entry when it is empty or is
  // being consumed this cycle.
  assign rsp_free = !rsp_valid || rsp_ready;

  // Oversized, misaligned, or a Put wider than one bus word.
  assign cmd_illegal = (int'(cmd_size) > MAX_SIZE) ||
                       ((cmd_address & ((32'd1 << cmd_size) - 32'd1)) != 32'd0) ||
                       (cmd_write && (int'(cmd_size) > LB));

  assign beats      = beat_count(cmd_write_q, cmd_size_q, LB);
  assign final_beat = ({1'b0, beat_cnt} == (beats - 5'd1));

  assign d_mismatch = (d_bits_opcode != expected_d_opcode(cmd_write_q)) ||
                      (d_bits_source != SRC_W'(SOURCE_ID)) ||
                      (d_bits_size != cmd_size_q);

  // A handshake in the same cycle resets the watchdog, so it must not fire.
  assign timeout = ((state == REQ) || (state == RESP)) &&
                   (wd_cnt == WD_W'(TIMEOUT - 1)) && !a_fire && !d_fire;

  assign load_d    = (state == RESP) && d_fire;
  assign load_err  = (cmd_fire && cmd_illegal && rsp_free) ||
                     ((state == ERR) && !err_sent && rsp_free);
  assign load_hang = (timeout && rsp_free) ||
                     ((state == HUNG) && hang_rsp_pending && rsp_free);

  // Channel A fields come straight from the latched command so they stay
  // stable for as long as a_valid waits on a_ready.
  assign a_bits_opcode  = cmd_write_q ? A_PUT_FULL_DATA : A_GET;
  assign a_bits_param   = 3'd0;
  assign a_bits_size    = cmd_size_q;
  assign a_bits_source  = SRC_W'(SOURCE_ID);
  assign a_bits_address = cmd_address_q;
  assign a_bits_data    = cmd_data_q;

  tilelink_ad_mask_gen #(
    .BYTES (BYTES),
    .LB    (LB)
  ) u_mask_gen (
    .size      (cmd_size_q),
    .addr_lsbs (cmd_address_q[LB-1:0]),
    .mask      (a_bits_mask)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. d_ready in RESP only opens when the
  // response slot can accept the beat, so no beat is ever dropped. HUNG
  // sinks any late D traffic without reporting it.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    a_valid    = 1'b0;
    d_ready    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = reset_n;
        if (cmd_fire) begin
          state_next = cmd_illegal ? ERR : REQ;
        end
      end
      REQ: begin
        a_valid = 1'b1;
        if (timeout) begin
          state_next = HUNG;
        end else if (a_fire) begin
          state_next = RESP;
        end
      end
      RESP: begin
        d_ready = rsp_free;
        if (timeout) begin
          state_next = HUNG;
        end else if (d_fire && final_beat) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        if (err_sent && rsp_fire) begin
          state_next = IDLE;
        end
      end
      HUNG: begin
        d_ready = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latch, counters, response register and sticky flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cmd_write_q      <= 1'b0;
      cmd_address_q    <= '0;
      cmd_size_q       <= '0;
      cmd_data_q       <= '0;
      beat_cnt         <= '0;
      wd_cnt           <= '0;
      err_sent         <= 1'b0;
      hang_rsp_pending <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_last         <= 1'b0;
      rsp_error        <= 1'b0;
      proto_err        <= 1'b0;
      hung             <= 1'b0;
    end else begin
      if (cmd_fire) begin
        cmd_write_q   <= cmd_write;
        cmd_address_q <= cmd_address;
        cmd_size_q    <= cmd_size;
        cmd_data_q    <= cmd_data;
      end

      // Watchdog: restarts on every transfer, only runs while waiting on
      // the bus.
      if (cmd_fire || a_fire || d_fire) begin
        wd_cnt <= '0;
      end else if ((state == REQ) || (state == RESP)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end

      // Beat counter stops on the final beat rather than wrapping.
      if (cmd_fire) begin
        beat_cnt <= '0;
      end else if (load_d && !final_beat) begin
        beat_cnt <= beat_cnt + 4'd1;
      end

      if (cmd_fire) begin
        err_sent <= cmd_illegal && rsp_free;
      end else if ((state == ERR) && !err_sent && rsp_free) begin
        err_sent <= 1'b1;
      end

      if (timeout) begin
        hang_rsp_pending <= !rsp_free;
      end else if ((state == HUNG) && rsp_free) begin
        hang_rsp_pending <= 1'b0;
      end

      if (load_d) begin
        rsp_valid <= 1'b1;
        rsp_data  <= d_bits_data;
        rsp_last  <= final_beat;
        rsp_error <= d_mismatch;
      end else if (load_err || load_hang) begin
        rsp_valid <= 1'b1;
        rsp_data  <= '0;
        rsp_last  <= 1'b1;
        rsp_error <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end

      if (load_d && d_mismatch) begin
        proto_err <= 1'b1;
      end

      if (timeout) begin
        hung <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tilelink_ad_initiator.sv
// tb_tilelink_ad_initiator
// Directed bench for tilelink_ad_initiator (XLEN=32, TIMEOUT=16). Inputs
// change on the falling edge; outputs are sampled on the falling edge.
module tb_tilelink_ad_initiator;

  logic        clock;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_data;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_bits_opcode;
  logic [2:0]  a_bits_param;
  logic [2:0]  a_bits_size;
  logic [4:0]  a_bits_source;
  logic [31:0] a_bits_address;
  logic [3:0]  a_bits_mask;
  logic [31:0] a_bits_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_bits_opcode;
  logic [2:0]  d_bits_size;
  logic [4:0]  d_bits_source;
  logic [31:0] d_bits_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_error;
  logic        proto_err;
  logic        hung;

  int testsRun = 0;
  int testsFailed = 0;

  tilelink_ad_initiator #(
    .XLEN      (32),
    .SRC_W     (5),
    .SOURCE_ID (0),
    .MAX_SIZE  (6),
    .TIMEOUT   (16)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_address    (cmd_address),
    .cmd_size       (cmd_size),
    .cmd_data       (cmd_data),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_bits_opcode  (a_bits_opcode),
    .a_bits_param   (a_bits_param),
    .a_bits_size    (a_bits_size),
    .a_bits_source  (a_bits_source),
    .a_bits_address (a_bits_address),
    .a_bits_mask    (a_bits_mask),
    .a_bits_data    (a_bits_data),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_bits_opcode  (d_bits_opcode),
    .d_bits_size    (d_bits_size),
    .d_bits_source  (d_bits_source),
    .d_bits_data    (d_bits_data),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_last       (rsp_last),
    .rsp_error      (rsp_error),
    .proto_err      (proto_err),
    .hung           (hung)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present a command and hold it until it has been accepted; returns on the
  // falling edge right after the accepting clock edge.
  task automatic applyStimulus(input logic w, input logic [31:0] addr,
                               input logic [2:0] sz, input logic [31:0] data);
    int n;
    n = 0;
    cmd_valid   = 1'b1;
    cmd_write   = w;
    cmd_address = addr;
    cmd_size    = sz;
    cmd_data    = data;
    #1;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    checkOutput("cmd_accept", 64'(n < 20), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // One-beat transaction with immediate A acceptance and a single D beat.
  task automatic runSingleBeat(input string tag, input logic w,
                               input logic [31:0] addr, input logic [2:0] sz,
                               input logic [2:0] dop, input logic [4:0] dsrc,
                               input logic [31:0] ddata, input logic expErr,
                               input logic expProto);
    applyStimulus(w, addr, sz, 32'h0);
    checkOutput({tag, "_a_valid"}, 64'(a_valid), 64'd1);
    a_ready = 1'b1;
    tick();
    a_ready       = 1'b0;
    d_valid       = 1'b1;
    d_bits_opcode = dop;
    d_bits_size   = sz;
    d_bits_source = dsrc;
    d_bits_data   = ddata;
    tick();
    d_valid       = 1'b0;
    d_bits_source = 5'd0;
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    checkOutput({tag, "_rsp_data"}, 64'(rsp_data), 64'(ddata));
    checkOutput({tag, "_rsp_error"}, 64'(rsp_error), 64'(expErr));
    checkOutput({tag, "_proto_err"}, 64'(proto_err), 64'(expProto));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset_n       = 1'b0;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_address   = '0;
    cmd_size      = '0;
    cmd_data      = '0;
    a_ready       = 1'b0;
    d_valid       = 1'b0;
    d_bits_opcode = '0;
    d_bits_size   = '0;
    d_bits_source = '0;
    d_bits_data   = '0;
    rsp_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_a_valid", 64'(a_valid), 64'd0);
    checkOutput("rst_d_ready", 64'(d_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
    checkOutput("rst_hung", 64'(hung), 64'd0);
    checkOutput("rst_cmd_ready_low", 64'(cmd_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_cmd_ready_high", 64'(cmd_ready), 64'd1);
    tick();

    // Get 0x100 size 2, single AccessAckData beat
    applyStimulus(1'b0, 32'h100, 3'd2, 32'h0);
    checkOutput("get1_a_valid", 64'(a_valid), 64'd1);
    checkOutput("get1_a_opcode", 64'(a_bits_opcode), 64'd4);
    checkOutput("get1_a_param", 64'(a_bits_param), 64'd0);
    checkOutput("get1_a_size", 64'(a_bits_size), 64'd2);
    checkOutput("get1_a_source", 64'(a_bits_source), 64'd0);
    checkOutput("get1_a_address", 64'(a_bits_address), 64'h100);
    checkOutput("get1_a_mask", 64'(a_bits_mask), 64'hF);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    checkOutput("get1_a_dropped", 64'(a_valid), 64'd0);
    checkOutput("get1_d_ready", 64'(d_ready), 64'd1);
    d_valid       = 1'b1;
    d_bits_opcode = 3'd1;
    d_bits_size   = 3'd2;
    d_bits_source = 5'd0;
    d_bits_data   = 32'hDEADBEEF;
    tick();
    d_valid = 1'b0;
    checkOutput("get1_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("get1_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    checkOutput("get1_rsp_last", 64'(rsp_last), 64'd1);
    checkOutput("get1_rsp_error", 64'(rsp_error), 64'd0);
    checkOutput("get1_cmd_ready", 64'(cmd_ready), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("get1_rsp_drained", 64'(rsp_valid), 64'd0);

    // Get 0x40 size 4: four beats, response held for 3 cycles after beat 1
    applyStimulus(1'b0, 32'h40, 3'd4, 32'h0);
    checkOutput("get4_a_mask", 64'(a_bits_mask), 64'hF);
    a_ready = 1'b1;
    tick();
    a_ready       = 1'b0;
    d_valid       = 1'b1;
    d_bits_opcode = 3'd1;
    d_bits_size   = 3'd4;
    d_bits_source = 5'd0;
    d_bits_data   = 32'h1000;
    tick();
    d_bits_data = 32'h1001;
    checkOutput("get4_b0_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("get4_b0_rsp_data", 64'(rsp_data), 64'h1000);
    checkOutput("get4_b0_rsp_last", 64'(rsp_last), 64'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("get4_hold_d_ready", 64'(d_ready), 64'd0);
      checkOutput("get4_hold_rsp_data", 64'(rsp_data), 64'h1000);
      tick();
    end
    rsp_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      d_bits_data = 32'h1000 + 32'(b);
      #1;
      checkOutput("get4_d_ready", 64'(d_ready), 64'd1);
      tick();
      checkOutput("get4_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("get4_rsp_data", 64'(rsp_data), 64'h1000 + 64'(b));
      checkOutput("get4_rsp_last", 64'(rsp_last), 64'(b == 3));
      checkOutput("get4_rsp_error", 64'(rsp_error), 64'd0);
    end
    d_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    checkOutput("get4_rsp_drained", 64'(rsp_valid), 64'd0);
    checkOutput("get4_cmd_ready", 64'(cmd_ready), 64'd1);

    // Put 0x102 size 1 with a_ready delayed 5 cycles
    applyStimulus(1'b1, 32'h102, 3'd1, 32'hABCD0000);
    for (int c = 0; c < 5; c++) begin
      checkOutput("put_a_valid", 64'(a_valid), 64'd1);
      checkOutput("put_a_opcode", 64'(a_bits_opcode), 64'd0);
      checkOutput("put_a_address", 64'(a_bits_address), 64'h102);
      checkOutput("put_a_mask", 64'(a_bits_mask), 64'hC);
      checkOutput("put_a_data", 64'(a_bits_data), 64'hABCD0000);
      checkOutput("put_a_size", 64'(a_bits_size), 64'd1);
      tick();
    end
    a_ready = 1'b1;
    tick();
    a_ready       = 1'b0;
    d_valid       = 1'b1;
    d_bits_opcode = 3'd0;
    d_bits_size   = 3'd1;
    d_bits_source = 5'd0;
    d_bits_data   = 32'h0;
    tick();
    d_valid = 1'b0;
    checkOutput("put_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("put_rsp_last", 64'(rsp_last), 64'd1);
    checkOutput("put_rsp_error", 64'(rsp_error), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("put_rsp_drained", 64'(rsp_valid), 64'd0);

    // Wrong D source, then a clean Get: proto_err stays set
    runSingleBeat("badsrc", 1'b0, 32'h200, 3'd2, 3'd1, 5'd3, 32'h12345678,
                  1'b1, 1'b1);
    runSingleBeat("clean", 1'b0, 32'h204, 3'd2, 3'd1, 5'd0, 32'h87654321,
                  1'b0, 1'b1);

    // Get with no D response: watchdog fires 16 cycles after the A fire
    applyStimulus(1'b0, 32'h300, 3'd2, 32'h0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("wd_latency", 64'(n), 64'd16);
    checkOutput("wd_rsp_error", 64'(rsp_error), 64'd1);
    checkOutput("wd_rsp_last", 64'(rsp_last), 64'd1);
    checkOutput("wd_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("wd_hung", 64'(hung), 64'd1);
    checkOutput("wd_cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("wd_d_ready", 64'(d_ready), 64'd1);
    checkOutput("wd_a_valid", 64'(a_valid), 64'd0);
    reset_n = 1'b0;
    tick();
    checkOutput("wdrst_hung", 64'(hung), 64'd0);
    checkOutput("wdrst_proto_err", 64'(proto_err), 64'd0);
    checkOutput("wdrst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("wdrst_d_ready", 64'(d_ready), 64'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("wdrst_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();

    // Misaligned Get: no A traffic, error response next cycle
    applyStimulus(1'b0, 32'h101, 3'd2, 32'h0);
    checkOutput("misal_a_valid", 64'(a_valid), 64'd0);
    checkOutput("misal_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("misal_rsp_error", 64'(rsp_error), 64'd1);
    checkOutput("misal_rsp_last", 64'(rsp_last), 64'd1);
    checkOutput("misal_rsp_data", 64'(rsp_data), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("misal_rsp_drained", 64'(rsp_valid), 64'd0);
    checkOutput("misal_cmd_ready", 64'(cmd_ready), 64'd1);

    // Put wider than a bus word
    applyStimulus(1'b1, 32'h100, 3'd3, 32'h55);
    checkOutput("wideput_a_valid", 64'(a_valid), 64'd0);
    checkOutput("wideput_rsp_valid", 64'(rsp_valid), 64'd1);
    checkOutput("wideput_rsp_error", 64'(rsp_error), 64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("wideput_rsp_drained", 64'(rsp_valid), 64'd0);
    checkOutput("wideput_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("wideput_proto_err", 64'(proto_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
